md5_padder: RTL and testbench

Byte-stream front end for the `md5` compression core. It accepts a message one byte at a time and applies MD5 padding: a 0x80 marker, zero fill, and a 64-bit little-endian bit length. It emits complete 512-bit blocks over a valid/ready handshake, and integration glue maps each accepted block onto the core's `message`/`start` pair. Each block is laid out so that core word M[i] is `blk_data[32*i +: 32]`.

---
 rtl/md5_padder.sv | 161 ++++++++++++++++
 tb/tb_md5_padder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_padder.sv
// MD5 message padder: byte stream in, 512-bit padded blocks out over valid/ready.
// Optional MD5_PADDER_STATS_EN adds a completed-message counter output msg_count.
module md5_padder #(
  parameter int LEN_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ready
`ifdef MD5_PADDER_STATS_EN
  ,
  output logic [15:0]  msg_count
`endif
);

  typedef enum logic [1:0] {FILL, EMIT, PAD} state_t;

  state_t             state_q, state_d;
  logic [511:0]       blk_q, blk_d;
  logic [5:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               pend80_q, pend80_d;
  logic               owe_q, owe_d;
  logic               in_ready_q, in_ready_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [63:0]        len_inc, len_cur;
  logic [6:0]         p;
  logic               accept, xfer;

  assign accept = in_ready_q && in_valid;
  assign xfer   = vld_q && blk_ready;
  assign p      = {1'b0, idx_q} + 7'd1;

  // Bit lengths: len_inc includes the byte being accepted, len_cur is for PAD.
  always_comb begin
    cnt_inc = cnt_q + LEN_W'(1);
    len_inc = '0;
    len_inc[LEN_W+2:0] = {cnt_inc, 3'b000};
    len_cur = '0;
    len_cur[LEN_W+2:0] = {cnt_q, 3'b000};
  end

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pend80_d   = pend80_q;
    owe_d      = owe_q;
    in_ready_d = in_ready_q;
    vld_d      = vld_q;
    last_d     = last_q;
    case (state_q)
      FILL: begin
        in_ready_d = 1'b1;
        if (accept) begin
          blk_d[{idx_q, 3'b000} +: 8] = in_data;
          cnt_d = cnt_inc;
          if (!in_last && idx_q != 6'd63) begin
            idx_d = idx_q + 6'd1;
          end else begin
            state_d    = EMIT;
            vld_d      = 1'b1;
            in_ready_d = 1'b0;
            last_d     = 1'b0;
            owe_d      = 1'b0;
            if (in_last) begin
              if (p <= 7'd55) begin
                blk_d[{p[5:0], 3'b000} +: 8] = 8'h80;
                blk_d[511:448] = len_inc;
                last_d = 1'b1;
                cnt_d  = '0;
              end else if (p != 7'd64) begin
                blk_d[{p[5:0], 3'b000} +: 8] = 8'h80;
                owe_d = 1'b1;
              end else begin
                // Buffer is full: the marker moves to byte 0 of the pad block.
                pend80_d = 1'b1;
                owe_d    = 1'b1;
              end
            end
          end
        end
      end
      EMIT: begin
        if (xfer) begin
          blk_d  = '0;
          idx_d  = '0;
          vld_d  = 1'b0;
          last_d = 1'b0;
          if (owe_q) begin
            state_d = PAD;
          end else begin
            state_d    = FILL;
            in_ready_d = 1'b1;
          end
        end
      end
      PAD: begin
        blk_d = '0;
        if (pend80_q) blk_d[7:0] = 8'h80;
        blk_d[511:448] = len_cur;
        cnt_d    = '0;
        pend80_d = 1'b0;
        owe_d    = 1'b0;
        last_d   = 1'b1;
        vld_d    = 1'b1;
        state_d  = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      blk_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend80_q   <= 1'b0;
      owe_q      <= 1'b0;
      in_ready_q <= 1'b0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend80_q   <= pend80_d;
      owe_q      <= owe_d;
      in_ready_q <= in_ready_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_data  = blk_q;
  assign blk_valid = vld_q;
  assign blk_last  = last_q;

`ifdef MD5_PADDER_STATS_EN
  logic [15:0] msg_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               msg_count_q <= '0;
    else if (xfer && last_q) msg_count_q <= msg_count_q + 16'd1;
  end

  assign msg_count = msg_count_q;
`endif

endmodule

// File: tb/tb_md5_padder.sv
// Bench for md5_padder: padded-message reference model plus directed literal checks.
module tb_md5_padder;
  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid, in_last, in_ready;
  logic [511:0] blk_data;
  logic         blk_valid, blk_last, blk_ready;
`ifdef MD5_PADDER_STATS_EN
  logic [15:0]  msg_count;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {logic [511:0] d; logic last;} blk_t;

  int errors = 0, checks = 0, cyc = 0, rdy_mode = 1, last_acc_cyc = 0;
  blk_t         exp_q[$];
  logic [7:0]   acc[$];
  logic [511:0] xd[$];
  logic         xl[$];
  int           xc[$];

  md5_padder dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .blk_data(blk_data),
    .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready)
`ifdef MD5_PADDER_STATS_EN
    , .msg_count(msg_count)
`endif
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference: append bytes; full non-final blocks go out as-is, the final
  // chunk becomes msg ++ 0x80 ++ zeros ++ 64-bit LE bit length.
  function automatic void model_accept(input logic [7:0] b, input logic last);
    logic [7:0] p[$];
    logic [63:0] bl;
    blk_t e;
    int L, n, first;
    acc.push_back(b);
    L = acc.size();
    if (!last) begin
      if (L % 64 == 0) begin
        for (int j = 0; j < 64; j++) e.d[8*j +: 8] = acc[L-64+j];
        e.last = 1'b0;
        exp_q.push_back(e);
      end
      return;
    end
    p = acc;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(L) * 64'd8;
    for (int k = 0; k < 8; k++) p.push_back(bl[8*k +: 8]);
    n = p.size() / 64;
    first = (L - 1) / 64;
    for (int k = first; k < n; k++) begin
      for (int j = 0; j < 64; j++) e.d[8*j +: 8] = p[64*k+j];
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    acc.delete();
  endfunction

  function automatic bq_t mk(input int n, input int v);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back((v < 0) ? 8'($urandom) : 8'(v));
    return q;
  endfunction

  task automatic chk512(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Drive at posedge+1; in_ready read then is what the next edge samples.
  task automatic send(input bq_t msg, input bit with_last, input int gap_pct);
    int i = 0, budget = 0;
    while (i < msg.size()) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 20000) begin
        checks++; errors++;
        $display("FAIL send_timeout sent=%0d of %0d", i, msg.size());
        in_valid = 1'b0;
        return;
      end
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = msg[i];
        in_last  = with_last && (i == msg.size() - 1);
        if (in_ready) begin
          model_accept(msg[i], in_last);
          if (in_last) last_acc_cyc = cyc + 1;
          i++;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((exp_q.size() != 0 || blk_valid) && b < 3000) begin
      @(negedge clk); b++;
    end
    repeat (2) @(negedge clk);
    chki("idle_reached", int'(b < 3000), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    exp_q.delete(); acc.delete();
    repeat (2) @(negedge clk);
    chki("rst_in_ready", in_ready, 0);
    chki("rst_blk_valid", blk_valid, 0);
    chki("rst_blk_last", blk_last, 0);
    chk512("rst_blk_data", blk_data, '0);
`ifdef MD5_PADDER_STATS_EN
    chki("rst_msg_count", msg_count, 0);
`endif
    #2 reset = 1'b0;
    #1 chki("rst_ready_low_before_edge", in_ready, 0);
    @(negedge clk);
    chki("rst_ready_rises", in_ready, 1);
  endtask

  // Ready driver
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       blk_ready = 1'b0;
        1:       blk_ready = 1'b1;
        default: blk_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Compare every valid cycle against the model's head block.
  logic pv = 1'b0, pr = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0; pr = 1'b0;
    end else begin
      if (blk_valid) begin
        checks += 2;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_blk got=%h last=%b exp=none", blk_data, blk_last);
        end else if (blk_data !== exp_q[0].d || blk_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL blk_model got=%h/%b exp=%h/%b", blk_data, blk_last, exp_q[0].d, exp_q[0].last);
        end
        if (in_ready) begin
          errors++;
          $display("FAIL ready_during_emit got=1 exp=0");
        end
        if (blk_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          xd.push_back(blk_data); xl.push_back(blk_last); xc.push_back(cyc + 1);
        end
      end else if (pv && !pr) begin
        checks++; errors++;
        $display("FAIL valid_dropped got=0 exp=1");
      end
      pv = blk_valid; pr = blk_ready;
    end
  end

  initial begin
    bq_t m1, m2;
    logic [511:0] lit, cap;
    logic capl;
    int n0, b, len;
    int bset[12] = '{1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    do_reset();

    // "abc"
    rdy_mode = 1;
    n0 = xd.size();
    m1 = {8'h61, 8'h62, 8'h63};
    send(m1, 1, 0);
    wait_idle();
    chki("abc_nblk", xd.size() - n0, 1);
    lit = '0; lit[31:0] = 32'h80636261; lit[511:448] = 64'h18;
    if (xd.size() > n0) begin
      chk512("abc_data", xd[n0], lit);
      chki("abc_last", xl[n0], 1);
      chki("abc_latency", xc[n0] - last_acc_cyc, 1);
    end

    // 55 bytes: marker at byte 55, single block
    n0 = xd.size();
    send(mk(55, 8'h41), 1, 0);
    wait_idle();
    chki("b55_nblk", xd.size() - n0, 1);
    lit = '0;
    for (int j = 0; j < 55; j++) lit[8*j +: 8] = 8'h41;
    lit[55*8 +: 8] = 8'h80; lit[511:448] = 64'h1B8;
    if (xd.size() > n0) begin chk512("b55_data", xd[n0], lit); chki("b55_last", xl[n0], 1); end

    // 56 bytes: marker at byte 56, length in a second block
    n0 = xd.size();
    send(mk(56, 8'h41), 1, 0);
    wait_idle();
    chki("b56_nblk", xd.size() - n0, 2);
    lit = '0;
    for (int j = 0; j < 56; j++) lit[8*j +: 8] = 8'h41;
    lit[56*8 +: 8] = 8'h80;
    if (xd.size() > n0 + 1) begin
      chk512("b56_blk1", xd[n0], lit); chki("b56_last1", xl[n0], 0);
      lit = '0; lit[511:448] = 64'h1C0;
      chk512("b56_blk2", xd[n0+1], lit); chki("b56_last2", xl[n0+1], 1);
    end

    // 64 zero bytes: marker deferred to the pad block, one-cycle gap
    n0 = xd.size();
    send(mk(64, 0), 1, 0);
    wait_idle();
    chki("b64_nblk", xd.size() - n0, 2);
    if (xd.size() > n0 + 1) begin
      chk512("b64_blk1", xd[n0], '0); chki("b64_last1", xl[n0], 0);
      lit = '0; lit[7:0] = 8'h80; lit[511:448] = 64'h200;
      chk512("b64_blk2", xd[n0+1], lit); chki("b64_last2", xl[n0+1], 1);
      chki("b64_pad_gap", xc[n0+1] - xc[n0], 2);
    end

    // Backpressure
    rdy_mode = 0;
    m1 = mk(10, 8'h11); m2 = mk(5, 8'h22);
    fork
      begin send(m1, 1, 0); send(m2, 1, 0); end
      begin
        b = 0;
        while (!blk_valid && b < 200) begin @(negedge clk); b++; end
        chki("bp_valid_seen", int'(b < 200), 1);
        cap = blk_data; capl = blk_last; n0 = xd.size();
        repeat (10) @(negedge clk);
        chki("bp_hold_valid", blk_valid, 1);
        chki("bp_in_ready", in_ready, 0);
        chk512("bp_data_stable", blk_data, cap);
        chki("bp_last_stable", blk_last, capl);
        chki("bp_no_consume", acc.size(), 0);
        chki("bp_no_xfer", xd.size() - n0, 0);
        rdy_mode = 1;
        @(posedge clk); #2;
        rdy_mode = 0;
        repeat (4) @(negedge clk);
        chki("bp_one_xfer", xd.size() - n0, 1);
        rdy_mode = 1;
      end
    join
    wait_idle();

    // Reset in the middle of a message, then a fresh "abc"
    send(mk(30, 8'h55), 0, 0);
    do_reset();
    n0 = xd.size();
    m1 = {8'h61, 8'h62, 8'h63};
    send(m1, 1, 0);
    wait_idle();
    chki("rst_abc_nblk", xd.size() - n0, 1);
    lit = '0; lit[31:0] = 32'h80636261; lit[511:448] = 64'h18;
    if (xd.size() > n0) chk512("rst_abc_data", xd[n0], lit);
`ifdef MD5_PADDER_STATS_EN
    chki("rst_abc_msg_count", msg_count, 1);
`endif

    // Random messages, random gaps, random backpressure
    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      len = ($urandom_range(1) != 0) ? bset[$urandom_range(11)] : $urandom_range(200, 1);
      send(mk(len, -1), 1, $urandom_range(40));
    end
    wait_idle();
    chki("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
